// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table engine (state encoding, term-list modes).
package tt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EVAL  = 2'd1,
      SWEEP = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int MODE_POS = 1;  // mask lists maxterms: bit=1 -> s=0
   localparam int MODE_SOP = 0;  // mask lists minterms: bit=1 -> s=1

endpackage

// File: rtl/tt_store.sv
// Function table register with a 2**N_IN:1 lookup mux; stores the effective function, not the raw term list.
module tt_store
   import tt_pkg::*;
#(
   parameter int N_IN = 4,
   parameter int MODE = MODE_POS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [2**N_IN-1:0]   mask,
   input  logic [N_IN-1:0]      addr,
   output logic                 f
);

   localparam int DEPTH = 2**N_IN;

   logic [DEPTH-1:0] tbl_q, tbl_d;

   always_comb begin
      // NOTE: assign the default first so every path drives tbl_d and no latch is inferred.
      tbl_d = tbl_q;
      if (we) begin
         tbl_d = (MODE == MODE_POS) ? ~mask : mask;
      end
   end

   // NOTE: the table is a small flop bank, so resetting it is cheap; a real RAM would not be reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbl_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
         tbl_q <= tbl_d;
      end
   end

   assign f = tbl_q[addr];

endmodule

// File: rtl/truth_table_engine.sv
// Programmable N-variable boolean function unit: single evaluations or full-table sweeps.
// Define TERM_COUNT_EN to build the ones_cnt counter; otherwise ones_cnt is tied to 0.
module truth_table_engine
   import tt_pkg::*;
#(
   parameter int N_IN = 4,
   parameter int MODE = MODE_POS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_we,
   input  logic [2**N_IN-1:0]   cfg_mask,
   output logic                 cfg_err,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N_IN-1:0]      in_vec,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N_IN-1:0]      out_idx,
   output logic                 out_s,
   output logic                 busy,
   output logic                 done,
   output logic [N_IN:0]        ones_cnt
);

   localparam int              DEPTH    = 2**N_IN;
   localparam logic [N_IN-1:0] IDX_LAST = N_IN'(DEPTH - 1);

   state_e          state_q, state_d;
   logic [N_IN-1:0] idx_q, idx_d;
   logic            cfg_err_q, cfg_err_d;
   logic            idle, accept, f_bit;

   assign idle = (state_q == IDLE);

   // idx_q addresses the table both for a single evaluation and for the sweep position.
   tt_store #(.N_IN(N_IN), .MODE(MODE)) u_store (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (cfg_we & idle),
      .mask  (cfg_mask),
      .addr  (idx_q),
      .f     (f_bit)
   );

   assign out_valid = (state_q == EVAL) || (state_q == SWEEP);
   assign accept    = out_valid & out_ready;
   assign out_idx   = out_valid ? idx_q : '0;
   assign out_s     = out_valid & f_bit;
   assign in_ready  = rst_n & idle & ~start;
   assign busy      = ~idle;
   assign done      = (state_q == DONE);
   assign cfg_err   = cfg_err_q;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cfg_err_d = cfg_we & ~idle;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SWEEP;
               idx_d   = '0;
            end else if (in_valid) begin
               state_d = EVAL;
               idx_d   = in_vec;
            end
         end
         EVAL: begin
            if (out_ready) state_d = IDLE;
         end
         SWEEP: begin
            if (out_ready) begin
               if (idx_q == IDX_LAST) state_d = DONE;
               else                   idx_d   = idx_q + N_IN'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cfg_err_q <= cfg_err_d;
      end
   end

`ifdef TERM_COUNT_EN
   logic [N_IN:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (idle && start) begin
         cnt_d = '0;
      end else if ((state_q == SWEEP) && accept && f_bit) begin
         cnt_d = cnt_q + (N_IN+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign ones_cnt = cnt_q;
`else
   assign ones_cnt = '0;
`endif

endmodule

// File: tb/tb_truth_table_engine.sv
// Scoreboard bench: a maxterm (PoS) and a minterm (SoP) instance run the same function side by side.
module tb_truth_table_engine;

   typedef struct packed {
      logic [3:0] idx;
      logic       s;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic [15:0] cfg_mask_p = '0, cfg_mask_s = '0;
   logic        start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0]  in_vec = '0;

   logic        cfg_err_p, in_ready_p, ov_p, os_p, busy_p, done_p;
   logic [3:0]  oidx_p;
   logic [4:0]  cnt_p;
   logic        cfg_err_s, in_ready_s, ov_s, os_s, busy_s, done_s;
   logic [3:0]  oidx_s;
   logic [4:0]  cnt_s;

   int   checks = 0;
   int   failures = 0;
   exp_t sbq[$];

   logic       hold_pend = 1'b0;
   logic [3:0] held_idx;
   logic       held_s;

   always #5 clk = ~clk;

   truth_table_engine #(.N_IN(4), .MODE(1)) u_pos (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_mask(cfg_mask_p), .cfg_err(cfg_err_p),
      .start(start), .in_valid(in_valid), .in_ready(in_ready_p), .in_vec(in_vec),
      .out_valid(ov_p), .out_ready(out_ready), .out_idx(oidx_p), .out_s(os_p),
      .busy(busy_p), .done(done_p), .ones_cnt(cnt_p)
   );

   truth_table_engine #(.N_IN(4), .MODE(0)) u_sop (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_mask(cfg_mask_s), .cfg_err(cfg_err_s),
      .start(start), .in_valid(in_valid), .in_ready(in_ready_s), .in_vec(in_vec),
      .out_valid(ov_s), .out_ready(out_ready), .out_idx(oidx_s), .out_s(os_s),
      .busy(busy_s), .done(done_s), .ones_cnt(cnt_s)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Maxterm list: a set bit forces the function to 0 at that combination.
   function automatic logic model_f(input logic [15:0] maxterms, input int i);
      return ~maxterms[i];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_masks(input logic [15:0] maxterms);
      cfg_mask_p = maxterms;
      cfg_mask_s = ~maxterms;
   endtask

   task automatic push_sweep(input logic [15:0] maxterms, output int ones);
      exp_t e;
      ones = 0;
      for (int i = 0; i < 16; i++) begin
         e.idx = 4'(i);
         e.s   = model_f(maxterms, i);
         if (e.s) ones++;
         sbq.push_back(e);
      end
   endtask

   // Accepted beats are popped and compared; stalled beats must be repeated unchanged next cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (hold_pend) begin
            check("hold_valid", 32'(ov_p), 32'd1);
            check("hold_idx", 32'(oidx_p), 32'(held_idx));
            check("hold_s", 32'(os_p), 32'(held_s));
            hold_pend = 1'b0;
         end
         if (ov_p && out_ready) begin
            if (sbq.size() == 0) begin
               check("sb_extra_beat", 32'(ov_p), 32'd0);
            end else begin
               e = sbq.pop_front();
               check("beat_idx_pos", 32'(oidx_p), 32'(e.idx));
               check("beat_s_pos", 32'(os_p), 32'(e.s));
               check("beat_valid_sop", 32'(ov_s), 32'd1);
               check("beat_idx_sop", 32'(oidx_s), 32'(e.idx));
               check("beat_s_sop", 32'(os_s), 32'(e.s));
            end
         end else if (ov_p) begin
            hold_pend = 1'b1;
            held_idx  = oidx_p;
            held_s    = os_p;
         end
      end else begin
         hold_pend = 1'b0;
      end
   end

   task automatic do_sweep(input logic [15:0] maxterms, input bit rnd, input bit inject_cfg,
                           input bit with_eval, input bit with_cfg);
      int ones, exp_cnt, cyc;
      push_sweep(maxterms, ones);
`ifdef TERM_COUNT_EN
      exp_cnt = ones;
`else
      exp_cnt = 0;
`endif
      if (with_cfg) begin
         set_masks(maxterms);
         cfg_we = 1'b1;
      end
      if (with_eval) begin
         in_vec   = 4'd3;
         in_valid = 1'b1;
      end
      start     = 1'b1;
      out_ready = 1'b1;
      #1;
      check("in_ready_on_start_pos", 32'(in_ready_p), 32'd0);
      check("in_ready_on_start_sop", 32'(in_ready_s), 32'd0);
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      cyc      = 1;
      while (!done_p && cyc < 400) begin
         if (inject_cfg && cyc == 4) begin
            set_masks(16'hFFFF);
            cfg_we = 1'b1;
         end
         if (inject_cfg && cyc == 5) begin
            check("cfg_err_pulse_pos", 32'(cfg_err_p), 32'd1);
            check("cfg_err_pulse_sop", 32'(cfg_err_s), 32'd1);
            cfg_we = 1'b0;
         end
         if (inject_cfg && cyc == 6) check("cfg_err_one_cycle", 32'(cfg_err_p), 32'd0);
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         tick();
         cyc++;
      end
      check("done_seen_pos", 32'(done_p), 32'd1);
      check("done_seen_sop", 32'(done_s), 32'd1);
      if (!rnd) check("done_cycle", 32'(cyc), 32'd17);
      check("done_out_valid", 32'(ov_p), 32'd0);
      check("ones_cnt_pos", 32'(cnt_p), 32'(exp_cnt));
      check("ones_cnt_sop", 32'(cnt_s), 32'(exp_cnt));
      check("sb_drained", 32'(sbq.size()), 32'd0);
      tick();
      check("done_one_cycle", 32'(done_p), 32'd0);
      check("idle_after_done", 32'(busy_p), 32'd0);
      check("ones_cnt_held", 32'(cnt_p), 32'(exp_cnt));
      check("no_beat_after_done", 32'(ov_p), 32'd0);
      set_masks(maxterms);
   endtask

   task automatic do_eval(input logic [15:0] maxterms, input logic [3:0] v, input int stall);
      exp_t e;
      e.idx = v;
      e.s   = model_f(maxterms, int'(v));
      sbq.push_back(e);
      in_vec    = v;
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      #1;
      check("eval_in_ready", 32'(in_ready_p), 32'd1);
      tick();
      in_valid = 1'b0;
      check("eval_valid", 32'(ov_p), 32'd1);
      check("eval_idx", 32'(oidx_p), 32'(v));
      check("eval_s", 32'(os_p), 32'(e.s));
      check("eval_busy", 32'(busy_p), 32'd1);
      check("eval_in_ready_low", 32'(in_ready_p), 32'd0);
      for (int k = 0; k < stall; k++) begin
         tick();
         check("eval_stall_idx", 32'(oidx_p), 32'(v));
         check("eval_stall_s", 32'(os_p), 32'(e.s));
         check("eval_stall_in_ready", 32'(in_ready_s), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      check("eval_released", 32'(ov_p), 32'd0);
      check("eval_back_idle", 32'(in_ready_p), 32'd1);
      check("eval_sb_drained", 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      int n;
      #3;
      check("rst_out_valid", 32'(ov_p), 32'd0);
      check("rst_busy", 32'(busy_p), 32'd0);
      check("rst_done", 32'(done_p), 32'd0);
      check("rst_in_ready", 32'(in_ready_p), 32'd0);
      check("rst_ones_cnt", 32'(cnt_p), 32'd0);
      check("rst_cfg_err", 32'(cfg_err_s), 32'd0);
      #9;
      rst_n = 1'b1;
      tick();
      check("post_rst_in_ready", 32'(in_ready_p), 32'd1);

      set_masks(16'hE76B);
      cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
      check("cfg_idle_no_err", 32'(cfg_err_p), 32'd0);

      do_sweep(16'hE76B, 1'b0, 1'b0, 1'b0, 1'b0);
      do_eval(16'hE76B, 4'b0111, 3);
      do_eval(16'hE76B, 4'd0, 0);
      do_eval(16'hE76B, 4'd15, 1);
      do_sweep(16'hE76B, 1'b1, 1'b1, 1'b0, 1'b0);
      do_sweep(16'hE76B, 1'b0, 1'b0, 1'b0, 1'b0);
      do_sweep(16'hE76B, 1'b0, 1'b0, 1'b1, 1'b0);
      do_sweep(16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b1);

      begin
         int ones;
         push_sweep(16'h0F0F, ones);
      end
      start     = 1'b1;
      out_ready = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (oidx_p != 4'd5 && n < 50) begin
         tick();
         n++;
      end
      check("reached_idx5", 32'(oidx_p), 32'd5);
      rst_n = 1'b0;
      #1;
      sbq.delete();
      check("abort_out_valid", 32'(ov_p), 32'd0);
      check("abort_out_idx", 32'(oidx_p), 32'd0);
      check("abort_out_s", 32'(os_p), 32'd0);
      check("abort_busy", 32'(busy_p), 32'd0);
      check("abort_done", 32'(done_p), 32'd0);
      check("abort_ones_cnt", 32'(cnt_p), 32'd0);
      check("abort_sop_valid", 32'(ov_s), 32'd0);
      tick();
      check("abort_no_done", 32'(done_p), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("post_abort_done", 32'(done_p), 32'd0);
         check("post_abort_busy", 32'(busy_s), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
